// File: rtl/ahfp_cordic_sched.sv
//------------------------------------------------------------------------------
// Module  : ahfp_cordic_sched
// Brief   : Round-robin scheduler sharing one pipelined FP CORDIC rotator.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ahfp_cordic_sched #(
    parameter int          NREQ       = 4,
    parameter int          TAGW       = 2,
    parameter int          CORDIC_LAT = 63,
    parameter logic [31:0] K_INIT     = 32'h3F1B74EE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_theta,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [32*NREQ-1:0]   rsp_cos,
    output logic [32*NREQ-1:0]   rsp_sin,
    output logic [31:0]          cordic_x_start,
    output logic [31:0]          cordic_y_start,
    output logic [31:0]          cordic_theta,
    input  logic [31:0]          cordic_x_cos,
    input  logic [31:0]          cordic_y_sin,
    output logic [TAGW:0]        inflight_cnt
);

    localparam logic [1:0] C_S_IDLE = 2'd0;
    localparam logic [1:0] C_S_BUSY = 2'd1;
    localparam logic [1:0] C_S_DONE = 2'd2;

    logic [1:0]            r_state     [NREQ];
    logic [1:0]            w_state_nxt [NREQ];
    logic [NREQ-1:0]       w_elig;
    logic [NREQ-1:0]       w_grant;
    logic                  w_grant_any;
    logic [TAGW-1:0]       w_grant_idx;
    logic [TAGW-1:0]       w_ptr_nxt;
    logic [TAGW-1:0]       r_ptr;
    logic [CORDIC_LAT-1:0] r_dl_vld;
    logic [TAGW-1:0]       r_dl_tag    [CORDIC_LAT];
    logic                  w_exit_vld;
    logic [TAGW-1:0]       w_exit_tag;
    logic [31:0]           r_theta;
    logic [TAGW:0]         r_inflight;
    logic [32*NREQ-1:0]    r_cos;
    logic [32*NREQ-1:0]    r_sin;

    assign w_exit_vld = r_dl_vld[CORDIC_LAT-1];
    assign w_exit_tag = r_dl_tag[CORDIC_LAT-1];

    // Slot FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) r_state[i] <= C_S_IDLE;
        end else begin
            for (int i = 0; i < NREQ; i++) r_state[i] <= w_state_nxt[i];
        end
    end

    // Slot FSM: next state
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                C_S_IDLE: if (w_grant[i]) w_state_nxt[i] = C_S_BUSY;
                C_S_BUSY: if (w_exit_vld && (w_exit_tag == TAGW'(i))) w_state_nxt[i] = C_S_DONE;
                C_S_DONE: if (rsp_ready[i]) w_state_nxt[i] = C_S_IDLE;
                default:  w_state_nxt[i] = C_S_IDLE;
            endcase
        end
    end

    // Slot FSM: outputs (a DONE slot is not eligible even while being drained)
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = (r_state[i] == C_S_DONE);
            w_elig[i]    = req_valid[i] && (r_state[i] == C_S_IDLE);
        end
    end

    // Round-robin search starting at the pointer, wrapping modulo NREQ
    always_comb begin
        int idx;
        idx         = 0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!w_grant_any && w_elig[idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = TAGW'(idx);
            end
        end
        w_grant = '0;
        if (w_grant_any) w_grant[w_grant_idx] = 1'b1;
        w_ptr_nxt = (w_grant_idx == TAGW'(NREQ - 1)) ? '0 : w_grant_idx + TAGW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_theta    <= '0;
            r_dl_vld   <= '0;
            r_inflight <= '0;
        end else begin
            r_dl_vld <= {r_dl_vld[CORDIC_LAT-2:0], w_grant_any};
            if (w_grant_any) begin
                r_ptr   <= w_ptr_nxt;
                r_theta <= req_theta[32*w_grant_idx +: 32];
            end
            case ({w_grant_any, w_exit_vld})
                2'b10:   r_inflight <= r_inflight + (TAGW+1)'(1);
                2'b01:   r_inflight <= r_inflight - (TAGW+1)'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Tags need no reset: they are only consumed alongside a set valid bit
    always_ff @(posedge clk) begin
        r_dl_tag[0] <= w_grant_idx;
        for (int k = 1; k < CORDIC_LAT; k++) r_dl_tag[k] <= r_dl_tag[k-1];
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cos[32*gi +: 32] <= '0;
                    r_sin[32*gi +: 32] <= '0;
                end else if (w_exit_vld && (w_exit_tag == TAGW'(gi))) begin
                    r_cos[32*gi +: 32] <= cordic_x_cos;
                    r_sin[32*gi +: 32] <= cordic_y_sin;
                end
            end
        end
    endgenerate

    assign req_ready      = w_grant;
    assign rsp_cos        = r_cos;
    assign rsp_sin        = r_sin;
    assign cordic_x_start = K_INIT;
    assign cordic_y_start = '0;
    assign cordic_theta   = r_theta;
    assign inflight_cnt   = r_inflight;

endmodule

`default_nettype wire

// File: tb/tb_ahfp_cordic_sched.sv
//------------------------------------------------------------------------------
// Module  : tb_ahfp_cordic_sched
// Brief   : Bench for ahfp_cordic_sched with a behavioural rotator and slot model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ahfp_cordic_sched;

    localparam int          NREQ   = 4;
    localparam int          TAGW   = 2;
    localparam int          LAT    = 63;
    localparam logic [31:0] K_INIT = 32'h3F1B74EE;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_theta;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [32*NREQ-1:0]  rsp_cos;
    logic [32*NREQ-1:0]  rsp_sin;
    logic [31:0]         cordic_x_start;
    logic [31:0]         cordic_y_start;
    logic [31:0]         cordic_theta;
    logic [31:0]         cordic_x_cos;
    logic [31:0]         cordic_y_sin;
    logic [TAGW:0]       inflight_cnt;

    ahfp_cordic_sched #(.NREQ(NREQ), .TAGW(TAGW), .CORDIC_LAT(LAT), .K_INIT(K_INIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_theta(req_theta),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_cos(rsp_cos), .rsp_sin(rsp_sin),
        .cordic_x_start(cordic_x_start), .cordic_y_start(cordic_y_start),
        .cordic_theta(cordic_theta), .cordic_x_cos(cordic_x_cos), .cordic_y_sin(cordic_y_sin),
        .inflight_cnt(inflight_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // float32 <-> real via double bit fields (values stay in the normal range)
    function automatic real f2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) return 0.0;
        d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] rot_cos(input logic [31:0] th); return r2f($cos(f2r(th))); endfunction
    function automatic logic [31:0] rot_sin(input logic [31:0] th); return r2f($sin(f2r(th))); endfunction

    // Rotator stand-in: output at edge E+LAT reflects the theta registered at edge E
    logic [31:0] rot_pipe [LAT-1];
    always @(posedge clk) begin
        rot_pipe[0] <= cordic_theta;
        for (int k = 1; k < LAT-1; k++) rot_pipe[k] <= rot_pipe[k-1];
    end
    assign cordic_x_cos = rot_cos(rot_pipe[LAT-2]);
    assign cordic_y_sin = rot_sin(rot_pipe[LAT-2]);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: slot states 0=idle 1=busy 2=done, completion edge numbers
    int          mst  [NREQ];
    int          due  [NREQ];
    logic [31:0] mth  [NREQ];
    logic [31:0] mcos [NREQ];
    logic [31:0] msin [NREQ];
    logic [31:0] mtheta;
    int          mptr;
    int          cyc;
    bit          dir_on [NREQ];
    real         dir_c  [NREQ];
    real         dir_s  [NREQ];

    logic [NREQ-1:0] drv_valid;
    logic [NREQ-1:0] drv_rready;
    logic [31:0]     drv_theta [NREQ];
    bit              drop_on_grant;
    int              glog [$];
    int              gcyc [$];
    int              last_g;
    int              peak;

    function automatic void model_reset();
        for (int i = 0; i < NREQ; i++) begin
            mst[i] = 0; due[i] = 0; mth[i] = '0; mcos[i] = '0; msin[i] = '0;
            dir_on[i] = 1'b0; drv_theta[i] = '0;
        end
        mtheta = '0; mptr = 0; drv_valid = '0; drv_rready = '0;
    endfunction

    function automatic int model_inflight();
        int n = 0;
        for (int i = 0; i < NREQ; i++) if (mst[i] == 1) n++;
        return n;
    endfunction

    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++) begin
            int idx = (mptr + k) % NREQ;
            if (drv_valid[idx] && mst[idx] == 0) return idx;
        end
        return -1;
    endfunction

    function automatic void model_update(input int g);
        cyc++;
        for (int i = 0; i < NREQ; i++) begin
            case (mst[i])
                0: if (g == i) begin mst[i] = 1; due[i] = cyc + LAT; mth[i] = drv_theta[i]; end
                1: if (due[i] == cyc) begin mst[i] = 2; mcos[i] = rot_cos(mth[i]); msin[i] = rot_sin(mth[i]); end
                default: if (drv_rready[i]) mst[i] = 0;
            endcase
        end
        if (g >= 0) begin mtheta = drv_theta[g]; mptr = (g + 1) % NREQ; end
    endfunction

    function automatic real absr(input real r); return (r < 0.0) ? -r : r; endfunction

    task automatic check_outputs();
        for (int i = 0; i < NREQ; i++) begin
            check("rsp_valid", {31'd0, rsp_valid[i]}, {31'd0, mst[i] == 2});
            check("rsp_cos", rsp_cos[32*i +: 32], mcos[i]);
            check("rsp_sin", rsp_sin[32*i +: 32], msin[i]);
            if (mst[i] == 2 && dir_on[i]) begin
                check("cos_tol", {31'd0, absr(f2r(rsp_cos[32*i +: 32]) - dir_c[i]) < 2.0e-3}, 32'd1);
                check("sin_tol", {31'd0, absr(f2r(rsp_sin[32*i +: 32]) - dir_s[i]) < 2.0e-3}, 32'd1);
                dir_on[i] = 1'b0;
            end
        end
        check("inflight_cnt", {29'd0, inflight_cnt}, model_inflight());
        check("inflight_le_nreq", {31'd0, int'(inflight_cnt) <= NREQ}, 32'd1);
        check("cordic_theta", cordic_theta, mtheta);
        if (int'(inflight_cnt) > peak) peak = int'(inflight_cnt);
    endtask

    task automatic step();
        int g;
        @(negedge clk);
        check_outputs();
        req_valid = drv_valid;
        rsp_ready = drv_rready;
        for (int i = 0; i < NREQ; i++) req_theta[32*i +: 32] = drv_theta[i];
        #1;
        g = model_grant();
        check("req_ready", {28'd0, req_ready}, (g >= 0) ? (32'd1 << g) : 32'd0);
        @(posedge clk);
        model_update(g);
        last_g = g;
        if (g >= 0) begin
            glog.push_back(g);
            gcyc.push_back(cyc);
            if (drop_on_grant) drv_valid[g] = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_theta();
        int u = $urandom_range(0, 3141592);
        return r2f((real'(u) - 1570796.0) * 1.0e-6);
    endfunction

    function automatic void set_req(input int i, input logic [31:0] th, input bit dir, input real c, input real s);
        drv_valid[i] = 1'b1; drv_theta[i] = th; dir_on[i] = dir; dir_c[i] = c; dir_s[i] = s;
    endfunction

    task automatic hard_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        glog.delete(); gcyc.delete(); peak = 0;
    endtask

    task automatic drain();
        int n = 0;
        drv_valid = '0; drv_rready = '1;
        while ((model_inflight() != 0 || mst[0] + mst[1] + mst[2] + mst[3] != 0) && n < 200) begin
            step(); n++;
        end
        check("drain_timeout", {31'd0, n < 200}, 32'd1);
    endtask

    initial begin
        int  first;
        bit  seen;
        int  g1, g02, n, acc;
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_theta = '0;
        cyc = 0; peak = 0; last_g = -1; drop_on_grant = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check("rst_x_start", cordic_x_start, K_INIT);
        check("rst_y_start", cordic_y_start, 32'd0);
        check("rst_theta", cordic_theta, 32'd0);
        check("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", {30'd0, |rsp_cos, |rsp_sin}, 32'd0);
        check("rst_inflight", {29'd0, inflight_cnt}, 32'd0);

        // Single request at theta 0
        drv_rready = '1;
        set_req(0, 32'h0000_0000, 1'b1, 1.0, 0.0);
        seen = 1'b0; first = 0;
        for (int k = 0; k < 90; k++) begin
            step(); #1;
            if (!seen && rsp_valid[0]) begin seen = 1'b1; first = cyc + 1; end
        end
        check("single_seen", {31'd0, seen}, 32'd1);
        if (gcyc.size() > 0) check("single_latency", first - gcyc[0], LAT + 1);

        // Four requesters valid from reset
        hard_reset();
        drv_rready = '1;
        set_req(0, 32'h3F060A92, 1'b1, 0.8660254, 0.5);
        set_req(1, 32'h3F490FDB, 1'b1, 0.7071068, 0.7071068);
        set_req(2, 32'hBF060A92, 1'b1, 0.8660254, -0.5);
        set_req(3, 32'h3FC90FDB, 1'b1, 0.0, 1.0);
        repeat (80) step();
        check("four_ngrant", glog.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < glog.size()) begin
                check("four_order", glog[k], k);
                check("four_consec", gcyc[k] - gcyc[0], k);
            end
        end
        check("four_peak", peak, 32'd4);

        // Backpressure on requester 1
        drv_rready = 4'b1101;
        set_req(1, rand_theta(), 1'b0, 0.0, 0.0);
        n = 0;
        while (mst[1] != 2 && n < 100) begin step(); n++; end
        check("bp_timeout", {31'd0, n < 100}, 32'd1);
        g1 = 0; g02 = 0;
        for (int k = 0; k < 20; k++) begin
            drv_valid[1] = 1'b1;
            if (!drv_valid[0]) drv_theta[0] = rand_theta();
            if (!drv_valid[2]) drv_theta[2] = rand_theta();
            drv_valid[0] = 1'b1; drv_valid[2] = 1'b1;
            step();
            if (last_g == 1) g1++;
            if (last_g == 0 || last_g == 2) g02++;
        end
        check("bp_no_grant1", g1, 32'd0);
        check("bp_others_served", {31'd0, g02 > 0}, 32'd1);
        drv_rready[1] = 1'b1;
        step(); #1;
        check("bp_release_idle", {31'd0, rsp_valid[1]}, 32'd0);
        drain();

        // Fairness between requesters 0 and 2
        hard_reset();
        drop_on_grant = 1'b0; drv_rready = '1;
        set_req(0, rand_theta(), 1'b0, 0.0, 0.0);
        set_req(2, rand_theta(), 1'b0, 0.0, 0.0);
        repeat (300) step();
        check("fair_peak_le2", {31'd0, peak <= 2}, 32'd1);
        check("fair_count", {31'd0, glog.size() >= 4}, 32'd1);
        for (int j = 1; j < glog.size(); j++) check("fair_alternate", {31'd0, glog[j] != glog[j-1]}, 32'd1);
        drop_on_grant = 1'b1;
        drain();

        // Exit of requester 0 coincides with accept of requester 1
        glog.delete(); gcyc.delete();
        set_req(0, rand_theta(), 1'b0, 0.0, 0.0);
        n = 0;
        while (gcyc.size() == 0 && n < 20) begin step(); n++; end
        check("same_accept_timeout", {31'd0, n < 20}, 32'd1);
        acc = (gcyc.size() > 0) ? gcyc[0] : cyc;
        n = 0;
        while (cyc < acc + LAT - 1 && n < 100) begin step(); n++; end
        set_req(1, rand_theta(), 1'b0, 0.0, 0.0);
        step(); #1;
        check("same_exit_done", {31'd0, rsp_valid[0]}, 32'd1);
        check("same_grant1", last_g, 32'd1);
        check("same_inflight", {29'd0, inflight_cnt}, 32'd1);
        drain();

        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < NREQ; i++)
                if (!drv_valid[i] && $urandom_range(0, 3) == 0) set_req(i, rand_theta(), 1'b0, 0.0, 0.0);
            drv_rready = 4'($urandom);
            step();
        end
        drain();

        // Reset with three requests in flight
        drv_rready = '1;
        for (int i = 0; i < 3; i++) set_req(i, rand_theta(), 1'b0, 0.0, 0.0);
        n = 0;
        while (model_inflight() != 3 && n < 20) begin step(); n++; end
        check("midrst_reach3", model_inflight(), 32'd3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        req_valid = '0;
        #1;
        model_reset();
        check_outputs();
        check("midrst_x_start", cordic_x_start, K_INIT);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            step(); #1;
            if (|rsp_valid) seen = 1'b1;
        end
        check("midrst_no_rsp", {31'd0, seen}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ahfp_cordic_sched.md
Name: ahfp_cordic_sched

Overview:
- Round-robin scheduler that shares one pipelined floating-point CORDIC rotator (IEEE-754 single, 10 iterations, fixed latency) among NREQ requesters.
- Accepts angle requests with valid/ready and drives the rotator's x_start/y_start/theta inputs.
- Tracks each in-flight request with a tag delay line matched to the rotator latency.
- Steers each cos/sin result back to its requester's holding slot, which the requester drains with valid/ready.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TAGW, 2, tag width; must equal clog2(NREQ).
- CORDIC_LAT, 63, cycles from the rotator input change (this block's registered outputs) to the matching x_cos/y_sin; must equal the instantiated rotator's latency.
- K_INIT, 32'h3F1B74EE, x_start value (CORDIC gain 0.6072529).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept.
- req_theta  in  32*NREQ  packed angles, requester i at [32i+31:32i], radians, |theta| <= pi/2.
- rsp_valid  out  NREQ  result held for requester i.
- rsp_ready  in  NREQ  requester i consumes result.
- rsp_cos  out  32*NREQ  packed cos results.
- rsp_sin  out  32*NREQ  packed sin results.
- cordic_x_start  out  32  to rotator.
- cordic_y_start  out  32  to rotator.
- cordic_theta  out  32  to rotator.
- cordic_x_cos  in  32  from rotator.
- cordic_y_sin  in  32  from rotator.
- inflight_cnt  out  TAGW+1  number of requests in the rotator.

Behaviour:
- Reset (async assert, sync-released use):
  - all slots IDLE; rr pointer 0; tag delay line valid bits 0.
  - rsp_valid=0, rsp_cos/rsp_sin=0, cordic_theta=0, cordic_y_start=0, cordic_x_start=K_INIT, inflight_cnt=0.
- Per-slot FSM, one per requester:
  - IDLE -> BUSY on accept.
  - BUSY -> DONE when its tag exits the delay line.
  - DONE -> IDLE on rsp_valid&rsp_ready.
  - rsp_valid[i] = (state==DONE), registered.
- Arbitration (combinational):
  - eligible[i] = req_valid[i] & state[i]==IDLE.
  - Grant the first eligible index searching from the rr pointer upward, wrapping modulo NREQ.
  - req_ready = one-hot grant, or 0 if none eligible. At most one accept per cycle.
  - req_ready may depend on req_valid; req_valid must not depend on req_ready.
- On accept of requester g:
  - cordic_theta <= req_theta[g].
  - Push {1, g} into the delay line head.
  - Pointer <= (g+1) mod NREQ; pointer is unchanged when there is no grant.
  - With no accept, push {0, x}; cordic_theta holds its value.
  - cordic_x_start/cordic_y_start are constant K_INIT/0.
- Delay line: CORDIC_LAT entries. Entry pushed at edge E exits at edge E+CORDIC_LAT.
  - On a valid exit with tag t: rsp_cos[t] <= cordic_x_cos, rsp_sin[t] <= cordic_y_sin, slot t -> DONE.
  - Result visible CORDIC_LAT+1 edges after the accept edge.
- A slot has at most one outstanding request, so results never collide and no output backpressure reaches the rotator.
- Simultaneous events:
  - DONE->IDLE in the same cycle as a new request from that requester: that requester is not eligible until the next cycle.
  - Exit for slot t and accept for slot g in the same cycle: both take effect.
- inflight_cnt:
  - +1 on accept, -1 on valid exit, unchanged when both occur.
  - Never exceeds NREQ.
- Results are held stable while rsp_valid=1 and rsp_ready=0.
- Reset mid-operation: in-flight requests are discarded. Stale rotator outputs after reset are ignored because the delay-line valid bits are cleared.
- theta outside ±pi/2 is passed through unchanged; the result is undefined for that angle but the protocol is unaffected.

Test Plan:
- Single request: req 0, theta=0x00000000, rsp_ready=1 -> rsp_valid[0] high exactly CORDIC_LAT+1 edges after accept; cos within 2e-3 of 1.0 (0x3F800000); sin within 2e-3 of 0.
- Four requesters all valid from reset:
  - thetas 0x3F060A92 (pi/6), 0x3F490FDB (pi/4), 0xBF060A92 (-pi/6), 0x3FC90FDB (pi/2).
  - Grants in order 0,1,2,3 on consecutive cycles.
  - Results: cos/sin ≈ {0.866,0.5}, {0.7071,0.7071}, {0.866,-0.5}, {0,1}, each within 2e-3.
  - inflight_cnt reaches 4.
- Backpressure: hold rsp_ready[1]=0 for 20 cycles after its result -> rsp_cos[1]/rsp_sin[1] stable; requester 1 never granted while DONE; others keep being served; release -> IDLE next cycle.
- Fairness: requesters 0 and 2 valid continuously with rsp_ready=1 -> grants strictly alternate 0,2,0,2; inflight_cnt ≤ 2.
- Reset mid-flight: assert rst_n=0 when inflight_cnt=3 -> all outputs at reset values immediately; after release, no rsp_valid appears for the discarded requests.
- Same-cycle exit and accept: time requester 1's accept to coincide with requester 0's result exit -> both slots update correctly; inflight_cnt unchanged that cycle.
